cacheline_adaptor: RTL
======================

# cacheline_adaptor

Responder on the cache's physical-memory port: accepts one 256-bit cacheline read or write from `cache_control`/cache datapath and converts it into a 4-beat, 64-bit burst transaction on the external memory bus. It answers each request with a single-cycle `pmem_resp`. It sits between the L1 cache and main memory and is the only agent driving `pmem_resp` and `pmem_rdata`.

## Interface
- `LINE_WIDTH`, 256, cacheline width in bits
- `BURST_WIDTH`, 64, memory bus beat width in bits
- `BEATS`, 4, beats per line (LINE_WIDTH/BURST_WIDTH); fixed, not overridden
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pmem_address`  in  32  line address from cache; bits [4:0] ignored
- `pmem_read`  in  1  line read request, held until `pmem_resp`
- `pmem_write`  in  1  line write request, held until `pmem_resp`
- `pmem_wdata`  in  256  line to write
- `pmem_rdata`  out  256  assembled read line
- `pmem_resp`  out  1  one-cycle completion pulse
- `mem_address`  out  32  burst base address, bits [4:0] = 0
- `mem_read`  out  1  burst read request
- `mem_write`  out  1  burst write request
- `mem_burst_o`  out  64  write beat data
- `mem_burst_i`  in  64  read beat data
- `mem_resp_i`  in  1  beat accepted (write) / beat valid (read)

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: if `pmem_read`, latch `{pmem_address[31:5],5'b0}`, clear beat counter, go RD_BURST. Else if `pmem_write`, also latch `pmem_wdata`, go WR_BURST. Read wins if both are high.
- RD_BURST: `mem_read`=1. On each cycle with `mem_resp_i`=1, store `mem_burst_i` into line bits [64k+63:64k] (k = counter, beat 0 = lowest), then k++. Beats may be non-consecutive. After beat 3, go DONE.
- WR_BURST: `mem_write`=1, `mem_burst_o` = latched line bits [64k+63:64k]. Advance k on `mem_resp_i`. After beat 3, go DONE.
- DONE: `pmem_resp`=1 for exactly one cycle. `mem_read` = `mem_write` = 0. Next state IDLE.
- Counter is 2 bits and wraps 3→0 when the last beat is taken. It is never used beyond 3.
- `mem_address` is driven from the latched register for the whole burst. Changes on `pmem_*` inputs during a transaction are ignored.
- `pmem_rdata` comes from the line register. It is valid in the DONE cycle and holds until the next read beat 0 overwrites it. Writes do not alter it.
- `mem_resp_i` is ignored in IDLE and DONE.

## Timing
- Reset (async assert): state IDLE, counter 0, line and address registers 0. All outputs are 0: `pmem_resp`, `mem_read`, `mem_write`, `mem_address`, `mem_burst_o`, `pmem_rdata`.
- Reset mid-burst: `mem_read`/`mem_write` drop immediately, with no `pmem_resp`. After release, the block restarts from IDLE.
- Request sampled at edge 0: `mem_read`/`mem_write` high from cycle 1.
- With back-to-back `mem_resp_i`, beats are taken in cycles 1–4 and `pmem_resp` is high in cycle 5. Latency is 5 cycles minimum, plus 1 cycle for each stall cycle (no `mem_resp_i`).
- The cache holds its request until `pmem_resp` and drops it the cycle after. IDLE re-samples only on the cycle after DONE, so no duplicate burst is issued.
- Outputs are decoded from registered state only. There is no combinational path from `mem_resp_i` to `pmem_resp`.
- Back-to-back requests: minimum spacing is 6 cycles from one request sample to the next (one IDLE cycle between DONE and the next burst).

## Test plan
- Read, no stalls: `pmem_read`, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → `mem_address`=0x0000_1220, `pmem_resp` in cycle 5, `pmem_rdata`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Read with stalls: `mem_resp_i` low for 2 cycles before beat 1 and 1 cycle before beat 3 → `pmem_resp` in cycle 8, data identical, `mem_read` continuously high in cycles 1–7.
- Write: `pmem_wdata`={D3,D2,D1,D0}, addr 0x8000_00E0 → `mem_burst_o` = D0, D1, D2, D3 on successive accepted beats. `mem_write` drops and `pmem_resp` pulses one cycle later. `pmem_rdata` unchanged.
- Simultaneous `pmem_read` and `pmem_write` → read burst only, `mem_write` never asserted.
- Reset during beat 2 of a read → `mem_read` low asynchronously, no `pmem_resp`. A subsequent read completes in 5 cycles with correct data.
- Spurious `mem_resp_i` in IDLE/DONE → no state change, `pmem_rdata` unchanged, no extra `pmem_resp`.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts one 256-bit cacheline read/write into a 4-beat 64-bit memory burst
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pmem_address,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic [31:0]            mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BURST_WIDTH-1:0] mem_burst_o,
  input  logic [BURST_WIDTH-1:0] mem_burst_i,
  input  logic                   mem_resp_i
);
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  state_t state;
  logic [1:0] cnt;
  logic [LINE_WIDTH-1:0] line, wline;
  logic [31:0] addr;
  wire last = cnt == 2'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      line  <= '0;
      wline <= '0;
      addr  <= '0;
    end else
      case (state)
        IDLE:
          if (pmem_read || pmem_write) begin
            addr  <= pmem_address & 32'hFFFF_FFE0;
            cnt   <= '0;
            state <= pmem_read ? RD_BURST : WR_BURST;
            if (!pmem_read) wline <= pmem_wdata;
          end
        RD_BURST:
          if (mem_resp_i) begin
            line[cnt*BURST_WIDTH +: BURST_WIDTH] <= mem_burst_i;
            cnt <= cnt + 2'd1;
            if (last) state <= DONE;
          end
        WR_BURST:
          if (mem_resp_i) begin
            cnt <= cnt + 2'd1;
            if (last) state <= DONE;
          end
        default: state <= IDLE;
      endcase
  // Outputs depend only on registered state, so mem_resp_i never reaches pmem_resp combinationally.
  assign mem_read    = state == RD_BURST;
  assign mem_write   = state == WR_BURST;
  assign pmem_resp   = state == DONE;
  assign mem_address = addr;
  assign pmem_rdata  = line;
  assign mem_burst_o = wline[cnt*BURST_WIDTH +: BURST_WIDTH];
endmodule
